spike_residue: RTL and testbench

Clocked threshold-and-fire stage of the PE neuron datapath. Takes one unsigned membrane-potential token per handshake and compares it against a compile-time threshold. Emits a 1-bit spike token and a WIDTH-bit residue token on two independent output channels. Sits between the PE accumulator and the spike-output and potential-writeback paths.

---
 rtl/spike_residue.sv | 125 ++++++++++++
 tb/tb_spike_residue.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_residue.sv
// -----------------------------------------------------------------------------
// spike_residue
//
// Threshold-and-fire stage of the PE neuron datapath. One unsigned membrane
// potential is accepted per input handshake and compared against THRESHOLD.
// The result forks into two independent single-entry output slots:
//   - spike   : 1 = fire, 0 = no fire
//   - residue : post-fire potential written back to the accumulator
//
// Handshake semantics (all three channels):
//   A transfer happens on a rising clock edge where valid && ready are both
//   high. A slot holds its data stable while valid is high and ready is low.
//   The input is taken only when both output slots are empty or draining in
//   the same cycle, so l_ready depends only on the output valids/readies and
//   never on l_valid or l_data.
//
// Configuration macro:
//   SPIKE_RESIDUE_RESET_ZERO_EN
//     defined   : on a spike the residue is 0 (reset-to-zero neuron)
//     undefined : on a spike the residue is l_data - THRESHOLD
//                 (reset-by-subtraction, default)
//
// Parameters:
//   WIDTH      bit width of membrane potential and residue
//   THRESHOLD  unsigned firing threshold, 1 .. 2**WIDTH-1
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   l_data         incoming membrane potential
//   l_valid        producer has a potential on l_data
//   l_ready        block accepts l_data this cycle
//   spike_data     spike token (1 = fire)
//   spike_valid    spike token pending
//   spike_ready    spike consumer accepts
//   residue_data   residue token
//   residue_valid  residue token pending
//   residue_ready  residue consumer accepts
//   spike_cnt      spikes emitted since reset, wraps modulo 2**16
// -----------------------------------------------------------------------------
module spike_residue #(
    parameter int          WIDTH     = 8,
    parameter int unsigned THRESHOLD = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] l_data,
    input  logic             l_valid,
    output logic             l_ready,
    output logic             spike_data,
    output logic             spike_valid,
    input  logic             spike_ready,
    output logic [WIDTH-1:0] residue_data,
    output logic             residue_valid,
    input  logic             residue_ready,
    output logic [15:0]      spike_cnt
);

    // Reject a threshold that can never fire (0) or cannot be represented.
    if (THRESHOLD < 1 || longint'(THRESHOLD) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_threshold
        $error("spike_residue: THRESHOLD out of range 1..2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] THR = WIDTH'(THRESHOLD);

    logic             in_xfer;
    logic             spike_xfer;
    logic             residue_xfer;
    logic             fire;
    logic [WIDTH-1:0] next_residue;

    // A slot can take a new token if it is empty or being drained this edge.
    assign l_ready      = (!spike_valid || spike_ready) && (!residue_valid || residue_ready);
    assign in_xfer      = l_valid && l_ready;
    assign spike_xfer   = spike_valid && spike_ready;
    assign residue_xfer = residue_valid && residue_ready;

    // Unsigned compare; when fire is set l_data >= THR so the subtract
    // cannot underflow.
    assign fire = (l_data >= THR);

`ifdef SPIKE_RESIDUE_RESET_ZERO_EN
    assign next_residue = fire ? '0 : l_data;
`else
    assign next_residue = fire ? (l_data - THR) : l_data;
`endif

    // Spike slot. A load on the same edge as a drain is a replace, so the
    // load branch has priority and valid stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_valid <= 1'b0;
            spike_data  <= 1'b0;
        end else if (in_xfer) begin
            spike_valid <= 1'b1;
            spike_data  <= fire;
        end else if (spike_xfer) begin
            spike_valid <= 1'b0;
        end
    end

    // Residue slot, same load/replace/drain behaviour as the spike slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            residue_valid <= 1'b0;
            residue_data  <= '0;
        end else if (in_xfer) begin
            residue_valid <= 1'b1;
            residue_data  <= next_residue;
        end else if (residue_xfer) begin
            residue_valid <= 1'b0;
        end
    end

    // Counted when the spike is produced (input transfer), not when the
    // spike consumer takes it; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_cnt <= '0;
        end else if (in_xfer && fire) begin
            spike_cnt <= spike_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_spike_residue.sv
// -----------------------------------------------------------------------------
// tb_spike_residue
//
// Self-checking bench for spike_residue (WIDTH=8, THRESHOLD=64). Expected
// spike/residue tokens are queued when an input transfer is seen and popped
// when the matching output transfer is seen. A vector table covers the main
// firing patterns; hand-written sequences cover reset, fork backpressure,
// stall, random traffic and counter wrap.
// -----------------------------------------------------------------------------
module tb_spike_residue;

    localparam int W   = 8;
    localparam int THR = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] l_data;
    logic         l_valid;
    logic         l_ready;
    logic         spike_data;
    logic         spike_valid;
    logic         spike_ready;
    logic [W-1:0] residue_data;
    logic         residue_valid;
    logic         residue_ready;
    logic [15:0]  spike_cnt;

    always #5 clk = ~clk;

    spike_residue #(.WIDTH(W), .THRESHOLD(THR)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .l_data        (l_data),
        .l_valid       (l_valid),
        .l_ready       (l_ready),
        .spike_data    (spike_data),
        .spike_valid   (spike_valid),
        .spike_ready   (spike_ready),
        .residue_data  (residue_data),
        .residue_valid (residue_valid),
        .residue_ready (residue_ready),
        .spike_cnt     (spike_cnt)
    );

    // ---------------------------------------------------------------- scoreboard
    int           total = 0;
    int           bad   = 0;
    logic         exp_sq[$];
    logic [W-1:0] exp_rq[$];
    logic         cur_s;
    logic [W-1:0] cur_r;
    logic [15:0]  exp_cnt = '0;
    int           acc_cnt = 0;
    int           cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [W-1:0] d, output logic s, output logic [W-1:0] r);
        s = (d >= W'(THR));
`ifdef SPIKE_RESIDUE_RESET_ZERO_EN
        r = s ? '0 : d;
`else
        r = s ? d - W'(THR) : d;
`endif
    endfunction

    always @(posedge clk) cyc++;

    // Monitor on the falling edge: inputs only change just after the rising
    // edge, so what is seen here is what the next rising edge will act on.
    always @(negedge clk) begin
        if (rst_n) begin
            check("spike_valid", spike_valid, exp_sq.size() != 0);
            check("residue_valid", residue_valid, exp_rq.size() != 0);
            check("l_ready", l_ready,
                  (exp_sq.size() == 0 || spike_ready) && (exp_rq.size() == 0 || residue_ready));
            if (exp_sq.size() != 0) check("spike_data", spike_data, exp_sq[0]);
            if (exp_rq.size() != 0) check("residue_data", residue_data, exp_rq[0]);
            if (spike_valid && spike_ready && exp_sq.size() != 0) void'(exp_sq.pop_front());
            if (residue_valid && residue_ready && exp_rq.size() != 0) void'(exp_rq.pop_front());
            if (l_valid && l_ready) begin
                exp_sq.push_back(cur_s);
                exp_rq.push_back(cur_r);
                acc_cnt++;
                if (cur_s) exp_cnt++;
            end
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic do_reset();
        rst_n = 1'b0;
        exp_sq.delete();
        exp_rq.delete();
        exp_cnt = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Offer one token and return just after the edge that accepts it.
    // l_valid is left high so back-to-back sends keep one token per cycle.
    task automatic send(input logic [W-1:0] d, input logic s, input logic [W-1:0] r);
        int n;
        bit done;
        l_data  = d;
        cur_s   = s;
        cur_r   = r;
        l_valid = 1'b1;
        n       = acc_cnt;
        done    = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != n) done = 1'b1;
        end
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        l_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic [W-1:0] d;
        logic         s;
        logic [W-1:0] r;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n0;
        int c0;
        int prev;
        logic [15:0] base;
        logic s;
        logic [W-1:0] r;

`ifdef SPIKE_RESIDUE_RESET_ZERO_EN
        vecs[0] = '{8'd100, 1'b1, 8'd0};
        vecs[1] = '{8'd64,  1'b1, 8'd0};
        vecs[2] = '{8'd63,  1'b0, 8'd63};
        vecs[3] = '{8'd0,   1'b0, 8'd0};
        vecs[4] = '{8'd30,  1'b0, 8'd30};
`else
        vecs[0] = '{8'd100, 1'b1, 8'd36};
        vecs[1] = '{8'd64,  1'b1, 8'd0};
        vecs[2] = '{8'd63,  1'b0, 8'd63};
        vecs[3] = '{8'd0,   1'b0, 8'd0};
        vecs[4] = '{8'd255, 1'b1, 8'd191};
`endif

        rst_n         = 1'b0;
        l_data        = '0;
        l_valid       = 1'b0;
        spike_ready   = 1'b0;
        residue_ready = 1'b0;
        cur_s         = 1'b0;
        cur_r         = '0;

        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check("rst_spike_valid", spike_valid, 0);
        check("rst_residue_valid", residue_valid, 0);
        check("rst_spike_data", spike_data, 0);
        check("rst_residue_data", residue_data, 0);
        check("rst_spike_cnt", spike_cnt, 0);
        check("rst_l_ready", l_ready, 1);
        rst_n = 1'b1;
        idle(2);

        // Table: back-to-back, both consumers ready.
        spike_ready   = 1'b1;
        residue_ready = 1'b1;
        n0 = acc_cnt;
        c0 = cyc;
        foreach (vecs[i]) send(vecs[i].d, vecs[i].s, vecs[i].r);
        check("tbl_accepts", acc_cnt - n0, 5);
        check("tbl_cycles", cyc - c0, 5);
        idle(3);
`ifdef SPIKE_RESIDUE_RESET_ZERO_EN
        check("tbl_spike_cnt", spike_cnt, 2);
`else
        check("tbl_spike_cnt", spike_cnt, 3);
`endif

        // Reset while tokens are pending.
        spike_ready   = 1'b0;
        residue_ready = 1'b0;
        send(8'd100, vecs[0].s, vecs[0].r);
        idle(1);
        rst_n = 1'b0;
        exp_sq.delete();
        exp_rq.delete();
        exp_cnt = '0;
        #1;
        check("mid_rst_spike_valid", spike_valid, 0);
        check("mid_rst_residue_valid", residue_valid, 0);
        check("mid_rst_spike_cnt", spike_cnt, 0);
        check("mid_rst_residue_data", residue_data, 0);
        check("mid_rst_l_ready", l_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        spike_ready   = 1'b1;
        residue_ready = 1'b1;
        idle(3);
        check("post_rst_no_token", spike_valid | residue_valid, 0);

        // Fork backpressure: residue drains, spike held, then spike drains
        // while the next input is taken on the same edge.
        spike_ready   = 1'b0;
        residue_ready = 1'b1;
        n0 = acc_cnt;
        send(8'd100, vecs[0].s, vecs[0].r);
        l_data = 8'd50;
        cur_s  = 1'b0;
        cur_r  = 8'd50;
        @(negedge clk);
        check("fork_l_ready_0", l_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("fork_spike_held", spike_valid, 1);
        check("fork_residue_done", residue_valid, 0);
        check("fork_l_ready_1", l_ready, 0);
        @(posedge clk);
        #1 spike_ready = 1'b1;
        @(negedge clk);
        check("fork_l_ready_2", l_ready, 1);
        @(posedge clk);
        #1;
        check("fork_accepts", acc_cnt - n0, 2);
        idle(3);

        // Stall: both readies low, l_valid held for 5 cycles.
        spike_ready   = 1'b0;
        residue_ready = 1'b0;
        base = exp_cnt;
        model(8'd150, s, r);
        send(8'd150, s, r);
        model(8'd20, s, r);
        l_data = 8'd20;
        cur_s  = s;
        cur_r  = r;
        n0 = acc_cnt;
        repeat (5) @(posedge clk);
        #1;
        check("stall_no_accept", acc_cnt - n0, 0);
        check("stall_spike_cnt", spike_cnt, base + 16'd1);
        spike_ready   = 1'b1;
        residue_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release_accept", acc_cnt - n0, 1);
        idle(3);

        // Random traffic with random backpressure.
        l_valid = 1'b0;
        prev    = acc_cnt;
        for (int k = 0; k < 400; k++) begin
            if (!l_valid || acc_cnt != prev) begin
                prev = acc_cnt;
                if ($urandom_range(0, 3) != 0) begin
                    l_data = W'($urandom_range(0, 255));
                    model(l_data, s, r);
                    cur_s   = s;
                    cur_r   = r;
                    l_valid = 1'b1;
                end else begin
                    l_valid = 1'b0;
                end
            end
            spike_ready   = ($urandom_range(0, 3) != 0);
            residue_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        spike_ready   = 1'b1;
        residue_ready = 1'b1;
        if (l_valid && acc_cnt == prev) send(l_data, cur_s, cur_r);
        idle(3);
        check("rand_spike_cnt", spike_cnt, exp_cnt);

        // Counter wrap: 65537 firing inputs from a clean reset.
        do_reset();
        model(8'd200, s, r);
        l_data  = 8'd200;
        cur_s   = s;
        cur_r   = r;
        l_valid = 1'b1;
        n0 = acc_cnt;
        repeat (65537) @(posedge clk);
        #1 l_valid = 1'b0;
        check("wrap_accepts", acc_cnt - n0, 65537);
        check("wrap_spike_cnt", spike_cnt, 1);
        idle(3);

        check("final_spike_q_empty", exp_sq.size(), 0);
        check("final_residue_q_empty", exp_rq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
